// File: rtl/dot_pass_sequencer_if.sv
// Layer-control and dot-engine handshake bundle seen by dot_pass_sequencer.
// master = sequencer side, slave = layer controller / engine / downstream side.
interface dot_pass_sequencer_if #(
    parameter int Q_W = 3072
);
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic           err;
    logic           dot_load;
    logic [3:0]     dot_cs;
    logic           dot_valid;
    logic [Q_W-1:0] dot_q;
    logic           out_valid;
    logic           out_ready;
    logic [Q_W-1:0] out_q;
    logic [3:0]     out_cs;

    modport master (
        input  start, abort, dot_valid, dot_q, out_ready,
        output busy, done, err, dot_load, dot_cs, out_valid, out_q, out_cs
    );

    modport slave (
        output start, abort, dot_valid, dot_q, out_ready,
        input  busy, done, err, dot_load, dot_cs, out_valid, out_q, out_cs
    );
endinterface

// File: rtl/dot_pass_sequencer.sv
// Steps the dot engine through NUM_CS weight-set passes per layer, buffering each
// wide result in a valid/ready stage, with a load-low gap, watchdog and abort.
module dot_pass_sequencer #(
    parameter int DATA_LEN = 8,
    parameter int Q_W      = 12*32*DATA_LEN,
    parameter int NUM_CS   = 12,
    parameter int GAP_CYC  = 2,
    parameter int TIMEOUT  = 4096
) (
    input logic                   clk_i,
    input logic                   rst_i,
    dot_pass_sequencer_if.master  seq_if
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam int GP_W = $clog2(GAP_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GP_W-1:0] GAP_LAST = GP_W'(GAP_CYC - 1);
    localparam logic [3:0]      CS_LAST  = 4'(NUM_CS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_GAP, S_FIN} state_e;

    state_e          state_q;
    logic            busy_q, done_q, err_q, load_q, ovalid_q;
    logic [3:0]      cs_q, ocs_q;
    logic [Q_W-1:0]  oq_q;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [GP_W-1:0] gap_q, gap_d;

    // Watchdog saturates; RUN exits on the terminal count anyway.
    assign wdog_d = (wdog_q == WD_LAST) ? wdog_q : wdog_q + 1'b1;
    assign gap_d  = gap_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            ovalid_q <= 1'b0;
            cs_q     <= '0;
            ocs_q    <= '0;
            oq_q     <= '0;
            wdog_q   <= '0;
            gap_q    <= '0;
        end else if (seq_if.abort) begin
            // Captured data and err are left alone; only the sequencing is torn down.
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            ovalid_q <= 1'b0;
            cs_q     <= '0;
            wdog_q   <= '0;
            gap_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seq_if.start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                        cs_q    <= '0;
                        err_q   <= 1'b0;
                        wdog_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (seq_if.dot_valid) begin
                        state_q  <= S_HOLD;
                        oq_q     <= seq_if.dot_q;
                        ocs_q    <= cs_q;
                        ovalid_q <= 1'b1;
                        load_q   <= 1'b0;
                    end else if (wdog_q == WD_LAST) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_HOLD: begin
                    if (ovalid_q && seq_if.out_ready) begin
                        ovalid_q <= 1'b0;
                        if (cs_q == CS_LAST) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                            cs_q    <= cs_q + 4'd1;
                            gap_q   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_RUN;
                        load_q  <= 1'b1;
                        wdog_q  <= '0;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cs_q    <= '0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    load_q   <= 1'b0;
                    ovalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.busy      = busy_q;
    assign seq_if.done      = done_q;
    assign seq_if.err       = err_q;
    assign seq_if.dot_load  = load_q;
    assign seq_if.dot_cs    = cs_q;
    assign seq_if.out_valid = ovalid_q;
    assign seq_if.out_q     = oq_q;
    assign seq_if.out_cs    = ocs_q;
endmodule

// File: tb/tb_dot_pass_sequencer.sv
// Random-latency engine model and pass scoreboard around two sequencer instances
// (12-pass with a short watchdog, and single-pass).
module tb_dot_pass_sequencer;
    localparam int QW  = 64;
    localparam int NCS = 12;
    localparam int GAP = 2;
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nd12  = 0;
    int   nd1   = 0;

    always #5 clk = ~clk;

    dot_pass_sequencer_if #(.Q_W(QW)) i12 ();
    dot_pass_sequencer_if #(.Q_W(QW)) i1 ();

    dot_pass_sequencer #(.Q_W(QW), .NUM_CS(NCS), .GAP_CYC(GAP), .TIMEOUT(TO)) u12 (
        .clk_i(clk), .rst_i(rst), .seq_if(i12.master));
    dot_pass_sequencer #(.Q_W(QW), .NUM_CS(1), .GAP_CYC(GAP), .TIMEOUT(TO)) u1 (
        .clk_i(clk), .rst_i(rst), .seq_if(i1.master));

    always @(negedge clk) begin
        if (i12.done) nd12++;
        if (i1.done)  nd1++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // mode 0: full layer; 1: reset while in RUN at pass ev; 2: abort in the GAP after pass ev.
    task automatic run_layer(input int mode, input int ev, input int fixlat, input int stall_cs);
        logic [63:0] q, qlast;
        int lat, n;
        qlast = '0;
        i12.out_ready = 1'b1;
        i12.start = 1'b1; tick(); i12.start = 1'b0;
        for (int cs = 0; cs < NCS; cs++) begin
            chk("load_rise", i12.dot_load, 1);
            chk("dot_cs", i12.dot_cs, cs);
            if (mode == 1 && cs == ev) begin
                tick(); tick();
                rst = 1'b1; tick(); rst = 1'b0;
                chk("rst_busy", i12.busy, 0);
                chk("rst_load", i12.dot_load, 0);
                chk("rst_cs", i12.dot_cs, 0);
                chk("rst_ovalid", i12.out_valid, 0);
                chk("rst_oq", i12.out_q, 0);
                chk("rst_ocs", i12.out_cs, 0);
                chk("rst_done", i12.done, 0);
                chk("rst_err", i12.err, 0);
                return;
            end
            lat = (fixlat >= 0) ? fixlat : int'($urandom_range(0, 50));
            repeat (lat) begin
                tick();
                chk("load_hold", i12.dot_load, 1);
            end
            q = rnd64();
            i12.dot_valid = 1'b1; i12.dot_q = q; tick(); i12.dot_valid = 1'b0;
            chk("ovalid", i12.out_valid, 1);
            chk("out_cs", i12.out_cs, cs);
            chk("out_q", i12.out_q, q);
            chk("load_drop", i12.dot_load, 0);
            qlast = q;
            if (cs == stall_cs) begin
                i12.out_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    i12.dot_valid = (k % 2 == 0); i12.dot_q = rnd64();
                    tick();
                    chk("stall_valid", i12.out_valid, 1);
                    chk("stall_q", i12.out_q, q);
                    chk("stall_cs", i12.out_cs, cs);
                    chk("stall_load", i12.dot_load, 0);
                end
                i12.dot_valid = 1'b0;
                i12.out_ready = 1'b1;
            end
            tick();
            chk("hs_clear", i12.out_valid, 0);
            if (cs == NCS - 1) begin
                chk("done", i12.done, 1);
                chk("busy_fin", i12.busy, 1);
                tick();
                chk("done_pulse", i12.done, 0);
                chk("busy_end", i12.busy, 0);
                chk("cs_end", i12.dot_cs, 0);
            end else begin
                chk("done_early", i12.done, 0);
                if (mode == 2 && cs == ev) begin
                    i12.abort = 1'b1; tick(); i12.abort = 1'b0;
                    chk("ab_busy", i12.busy, 0);
                    chk("ab_load", i12.dot_load, 0);
                    chk("ab_cs", i12.dot_cs, 0);
                    chk("ab_ovalid", i12.out_valid, 0);
                    chk("ab_done", i12.done, 0);
                    chk("ab_err", i12.err, 0);
                    i12.dot_valid = 1'b1; i12.dot_q = rnd64(); tick(); i12.dot_valid = 1'b0;
                    repeat (3) tick();
                    chk("ab_ign_valid", i12.out_valid, 0);
                    chk("ab_ign_q", i12.out_q, qlast);
                    chk("ab_ign_busy", i12.busy, 0);
                    return;
                end
                n = 0;
                while (!i12.dot_load && n < 20) begin
                    n++;
                    tick();
                end
                chk("gap_len", n, GAP);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [63:0] q;
        rst = 1'b1;
        i12.start = 0; i12.abort = 0; i12.dot_valid = 0; i12.dot_q = '0; i12.out_ready = 0;
        i1.start  = 0; i1.abort  = 0; i1.dot_valid  = 0; i1.dot_q  = '0; i1.out_ready  = 0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", i12.busy, 0);
        chk("reset_load", i12.dot_load, 0);
        chk("reset_cs", i12.dot_cs, 0);
        chk("reset_ovalid", i12.out_valid, 0);
        chk("reset_oq", i12.out_q, 0);
        chk("reset_flags", {i12.done, i12.err, i1.busy, i1.done}, 0);

        // abort beats start in IDLE
        i12.start = 1; i12.abort = 1; tick(); i12.start = 0; i12.abort = 0;
        chk("abst_busy", i12.busy, 0);
        chk("abst_load", i12.dot_load, 0);

        run_layer(0, -1, 40, -1);
        run_layer(0, -1, -1, 3);
        run_layer(1, 5, -1, -1);
        run_layer(0, -1, -1, -1);

        // watchdog: engine never answers
        i12.start = 1; tick(); i12.start = 0;
        chk("to_load", i12.dot_load, 1);
        repeat (63) tick();
        chk("to_busy64", i12.busy, 1);
        chk("to_err64", i12.err, 0);
        tick();
        chk("to_err", i12.err, 1);
        chk("to_busy", i12.busy, 0);
        chk("to_load0", i12.dot_load, 0);
        tick();
        chk("err_sticky", i12.err, 1);
        i12.start = 1; tick(); i12.start = 0;
        chk("err_clear", i12.err, 0);
        chk("restart_load", i12.dot_load, 1);
        i12.abort = 1; tick(); i12.abort = 0;
        chk("abort_run_busy", i12.busy, 0);
        chk("abort_run_load", i12.dot_load, 0);

        run_layer(2, 7, -1, -1);
        repeat (3) tick();
        chk("done_count12", nd12, 3);

        // single-pass instance: stray valid in IDLE, start while busy
        i1.dot_valid = 1; i1.dot_q = rnd64(); tick(); i1.dot_valid = 0;
        chk("s1_idle_valid", i1.out_valid, 0);
        chk("s1_idle_busy", i1.busy, 0);
        i1.out_ready = 1; i1.start = 1; tick();
        chk("s1_load", i1.dot_load, 1);
        chk("s1_cs", i1.dot_cs, 0);
        repeat (3) tick();
        i1.start = 0;
        q = rnd64();
        i1.dot_valid = 1; i1.dot_q = q; tick(); i1.dot_valid = 0;
        chk("s1_ovalid", i1.out_valid, 1);
        chk("s1_out_q", i1.out_q, q);
        chk("s1_out_cs", i1.out_cs, 0);
        tick();
        chk("s1_done", i1.done, 1);
        tick();
        chk("s1_done_pulse", i1.done, 0);
        chk("s1_busy_end", i1.busy, 0);
        i1.dot_valid = 1; tick(); i1.dot_valid = 0;
        repeat (4) tick();
        chk("s1_post_valid", i1.out_valid, 0);
        chk("done_count1", nd1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
